alu_result_fifo: RTL and testbench

//   Downstream stage of the 32-bit ALU. Captures each ALU result with its zero/overflow flags,

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_result_fifo_if.sv | 38 +++
 rtl/alu_res_regfile.sv | 21 ++
 rtl/alu_result_fifo.sv | 95 +++++++++
 tb/tb_alu_result_fifo.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU result FIFO definitions: opcodes, entry layout and the sticky-overflow rule.
package alu_pkg;
  localparam int ALU_W     = 32;
  localparam int ALU_TAG_W = 4;
  localparam int OP_W      = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL = 4'd6;
  localparam logic [OP_W-1:0] OP_LT  = 4'd7;
  localparam logic [OP_W-1:0] OP_GT  = 4'd8;

  // Field order here is the packing order used for the storage word.
  typedef struct packed {
    logic [ALU_W-1:0]     result;
    logic                 zero;
    logic                 overflow;
    logic [OP_W-1:0]      op;
    logic [ALU_TAG_W-1:0] tag;
  } alu_entry_t;

  localparam int ENTRY_W = $bits(alu_entry_t);

  // Only signed add/sub overflow is architecturally meaningful.
  function automatic logic sets_sticky(input logic [OP_W-1:0] op, input logic ovf);
    return ovf && ((op == OP_ADD) || (op == OP_SUB));
  endfunction
endpackage

// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU (master) and the result FIFO (slave).
interface alu_result_fifo_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic             in_zero;
   logic             in_overflow;
   logic [3:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_overflow;
   logic [3:0]       out_op;
   logic [TAG_W-1:0] out_tag;
   logic [CW-1:0]    count;
   logic             ovf_sticky;
   logic             clr_sticky;

   modport master (
      output in_valid, in_result, in_zero, in_overflow, in_op, in_tag, out_ready, clr_sticky,
      input  in_ready, out_valid, out_result, out_zero, out_overflow, out_op, out_tag,
             count, ovf_sticky
   );

   modport slave (
      input  in_valid, in_result, in_zero, in_overflow, in_op, in_tag, out_ready, clr_sticky,
      output in_ready, out_valid, out_result, out_zero, out_overflow, out_op, out_tag,
             count, ovf_sticky
   );
endinterface

// File: rtl/alu_res_regfile.sv
// DEPTH x EW storage, one synchronous write port and one asynchronous read port; no reset.
module alu_res_regfile #(
   parameter int DEPTH = 4,
   parameter int EW    = 42,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [EW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [EW-1:0] rdata_o
);
   logic [EW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/alu_result_fifo.sv
// FWFT result FIFO behind the ALU with a sticky ADD/SUB overflow bit.
// Optional same-cycle empty bypass: define ALU_RES_BYPASS_EN.
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W,
   parameter int DEPTH = 4,
   parameter int TAG_W = ALU_TAG_W
) (
   input logic               clk,
   input logic               rst,
   alu_result_fifo_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = WIDTH + 2 + OP_W + TAG_W;

   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] seen_q, seen_d;
   logic             sticky_q, sticky_d;
   logic             accept, push, pop, bypass, empty;
   logic [EW-1:0]    wdata, rdata, head, shown;

   assign empty  = (count_q == '0);
   assign accept = bus.in_valid && bus.in_ready;
   assign wdata  = {bus.in_result, bus.in_zero, bus.in_overflow, bus.in_op, bus.in_tag};

`ifdef ALU_RES_BYPASS_EN
   assign bypass = empty && bus.in_valid && bus.out_ready;
   assign shown  = bypass ? wdata : head;
`else
   assign bypass = 1'b0;
   assign shown  = head;
`endif

   // A bypassed word is consumed in flight and never touches storage.
   assign push = accept && !bypass;
   assign pop  = !empty && bus.out_ready;

   alu_res_regfile #(.DEPTH(DEPTH), .EW(EW)) u_regfile (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (wdata),
      .raddr_i (rptr_q),
      .rdata_o (rdata)
   );

   // Storage has no reset; slots not written since reset read as zero.
   assign head = seen_q[rptr_q] ? rdata : '0;

   assign bus.in_ready   = (count_q != CW'(DEPTH));
   assign bus.out_valid  = !empty || bypass;
   assign {bus.out_result, bus.out_zero, bus.out_overflow, bus.out_op, bus.out_tag} = shown;
   assign bus.count      = count_q;
   assign bus.ovf_sticky = sticky_q;

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      seen_d   = seen_q;
      sticky_d = sticky_q;
      if (push) begin
         wptr_d         = wptr_q + PW'(1);
         seen_d[wptr_q] = 1'b1;
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A setting push beats a same-cycle clear.
      if (accept && sets_sticky(bus.in_op, bus.in_overflow)) sticky_d = 1'b1;
      else if (bus.clr_sticky)                                  sticky_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         seen_q   <= '0;
         sticky_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         seen_q   <= seen_d;
         sticky_q <= sticky_d;
      end
   end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo; expectations follow ALU_RES_BYPASS_EN when defined.
module tb_alu_result_fifo;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   alu_result_fifo_if #(.WIDTH(32), .TAG_W(4), .DEPTH(4)) bus ();

   alu_result_fifo #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] op,
                        input logic ovf, input logic [3:0] tag);
      bus.in_valid    = v;
      bus.in_result   = res;
      bus.in_zero     = (res == 32'd0);
      bus.in_overflow = ovf;
      bus.in_op       = op;
      bus.in_tag      = tag;
   endtask

   task automatic test_reset();
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_result !== 32'd0 || bus.out_tag !== 4'd0 || bus.out_op !== 4'd0)
         begin errors++; $display("FAIL rst_out_fields got %h/%h/%h exp 0", bus.out_result, bus.out_op, bus.out_tag); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
      // Build up three entries with a sticky-setting ADD, then reset mid-stream.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h8000_0000, OP_ADD, 1'b1, 4'd1); tick();
      drive(1'b1, 32'h0000_0002, OP_OR,  1'b0, 4'd2); tick();
      drive(1'b1, 32'h0000_0003, OP_OR,  1'b0, 4'd3); tick();
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL pre_rst_count got %0d exp 3", bus.count); end
      checks++; if (bus.ovf_sticky !== 1'b1) begin errors++; $display("FAIL pre_rst_sticky got %b exp 1", bus.ovf_sticky); end
      rst = 1'b1;
      #1;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.ovf_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky got %b exp 0", bus.ovf_sticky); end
      checks++; if (bus.out_result !== 32'd0 || bus.out_tag !== 4'd0)
         begin errors++; $display("FAIL mid_rst_out got %h/%h exp 0/0", bus.out_result, bus.out_tag); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 32'(i * 16), OP_XOR, 1'b0, 4'(i));
         tick();
      end
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", bus.count); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", bus.in_ready); end
      drive(1'b1, 32'h55, OP_XOR, 1'b0, 4'd5); tick();
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_5th_count got %0d exp 4", bus.count); end
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'(i) || bus.out_result !== 32'(i * 16))
            begin errors++; $display("FAIL fill_drain_%0d got v=%b tag=%0d res=%h exp v=1 tag=%0d res=%h",
                                     i, bus.out_valid, bus.out_tag, bus.out_result, i, i * 16); end
         tick();
      end
      checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0)
         begin errors++; $display("FAIL fill_empty got count=%0d v=%b exp 0/0", bus.count, bus.out_valid); end
   endtask

   task automatic test_full_pop();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 32'(i), OP_AND, 1'b0, 4'(i));
         tick();
      end
      drive(1'b1, 32'h99, OP_AND, 1'b0, 4'd9);
      bus.out_ready = 1'b1;
      tick();
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      bus.out_ready = 1'b0;
      #1;
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d exp 3", bus.count); end
      checks++; if (bus.out_tag !== 4'd2) begin errors++; $display("FAIL full_pop_head got %0d exp 2", bus.out_tag); end
      bus.out_ready = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         checks++; if (bus.out_tag !== 4'(i)) begin errors++; $display("FAIL full_pop_drain got %0d exp %0d", bus.out_tag, i); end
         tick();
      end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL full_pop_end got %0d exp 0", bus.count); end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'(100 + i), OP_SUB, 1'b0, 4'(i));
         #1;
`ifdef ALU_RES_BYPASS_EN
         checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'(i) || bus.count !== 3'd0)
            begin errors++; $display("FAIL stream_%0d got v=%b tag=%0d cnt=%0d exp v=1 tag=%0d cnt=0",
                                     i, bus.out_valid, bus.out_tag, bus.count, i); end
`else
         if (i == 0) begin
            checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0)
               begin errors++; $display("FAIL stream_first got v=%b cnt=%0d exp 0/0", bus.out_valid, bus.count); end
         end else begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'(i - 1) ||
                          bus.out_result !== 32'(99 + i) || bus.count !== 3'd1)
               begin errors++; $display("FAIL stream_%0d got v=%b tag=%0d res=%0d cnt=%0d exp v=1 tag=%0d res=%0d cnt=1",
                                        i, bus.out_valid, bus.out_tag, bus.out_result, bus.count, i - 1, 99 + i); end
         end
`endif
         tick();
      end
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      #1;
`ifndef ALU_RES_BYPASS_EN
      checks++; if (bus.out_tag !== 4'd9 || bus.out_result !== 32'd109)
         begin errors++; $display("FAIL stream_last got tag=%0d res=%0d exp 9/109", bus.out_tag, bus.out_result); end
`endif
      tick();
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL stream_end got %0d exp 0", bus.count); end
   endtask

   task automatic test_sticky();
      bus.out_ready  = 1'b0;
      bus.clr_sticky = 1'b1;
      tick();
      bus.clr_sticky = 1'b0;
      drive(1'b1, 32'h1, OP_AND, 1'b1, 4'd3); tick();
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      checks++; if (bus.ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_and got %b exp 0", bus.ovf_sticky); end
      checks++; if (bus.out_overflow !== 1'b1 || bus.out_op !== OP_AND)
         begin errors++; $display("FAIL sticky_and_entry got ovf=%b op=%0d exp 1/%0d", bus.out_overflow, bus.out_op, OP_AND); end
      drive(1'b1, 32'h7FFF_FFFF + 32'd1, OP_ADD, 1'b1, 4'd4); tick();
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      checks++; if (bus.ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_add got %b exp 1", bus.ovf_sticky); end
      bus.clr_sticky = 1'b1; tick(); bus.clr_sticky = 1'b0;
      checks++; if (bus.ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr got %b exp 0", bus.ovf_sticky); end
      drive(1'b1, 32'h8000_0000, OP_SUB, 1'b1, 4'd5);
      bus.clr_sticky = 1'b1;
      tick();
      bus.clr_sticky = 1'b0;
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      checks++; if (bus.ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got %b exp 1", bus.ovf_sticky); end
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL sticky_count got %0d exp 3", bus.count); end
      bus.out_ready = 1'b1;
      tick(); tick(); tick();
      bus.clr_sticky = 1'b1; tick(); bus.clr_sticky = 1'b0;
      checks++; if (bus.count !== 3'd0 || bus.ovf_sticky !== 1'b0)
         begin errors++; $display("FAIL sticky_end got cnt=%0d st=%b exp 0/0", bus.count, bus.ovf_sticky); end
   endtask

   task automatic test_bypass();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h0000_0005, OP_ADD, 1'b0, 4'd6);
      #1;
`ifdef ALU_RES_BYPASS_EN
      checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd5)
         begin errors++; $display("FAIL bypass_same got v=%b res=%h exp 1/5", bus.out_valid, bus.out_result); end
      tick();
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", bus.count); end
`else
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL nobypass_same got v=%b exp 0", bus.out_valid); end
      tick();
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd5 || bus.count !== 3'd1)
         begin errors++; $display("FAIL nobypass_next got v=%b res=%h cnt=%0d exp 1/5/1", bus.out_valid, bus.out_result, bus.count); end
      tick();
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL nobypass_drain got %0d exp 0", bus.count); end
`endif
   endtask

   initial begin
      drive(1'b0, 32'd0, OP_ADD, 1'b0, 4'd0);
      bus.out_ready  = 1'b0;
      bus.clr_sticky = 1'b0;
      #12;
      rst = 1'b0;
      tick();
      test_reset();
      test_fill();
      test_full_pop();
      test_back_to_back();
      test_sticky();
      test_bypass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
